// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the posted-write store buffer.
package store_buffer_pkg;

  localparam int unsigned SB_DEPTH = 4;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_NONE    = 4'b0000;

  typedef struct packed {
    logic [29:0] word_addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] pc;
  } sb_entry_t;

  function automatic logic [29:0] word_of(input logic [31:0] byte_addr);
    return byte_addr[31:2];
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Store, load-probe and memory-drain signals of the store buffer.
interface store_buffer_if
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          st_valid;
  logic [31:0]   st_addr;
  logic [31:0]   st_wdata;
  logic [3:0]    st_be;
  logic [31:0]   st_pc;
  logic          st_ready;
  logic          ld_valid;
  logic [31:0]   ld_addr;
  logic          ld_hazard;
  logic          mem_req;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_be;
  logic [31:0]   mem_pc;
  logic          mem_ack;
  logic          empty;
  logic [CW-1:0] count;

  modport master (
    output st_valid, st_addr, st_wdata, st_be, st_pc, ld_valid, ld_addr, mem_ack,
    input  st_ready, ld_hazard, mem_req, mem_addr, mem_wdata, mem_be, mem_pc,
           empty, count
  );

  modport slave (
    input  st_valid, st_addr, st_wdata, st_be, st_pc, ld_valid, ld_addr, mem_ack,
    output st_ready, ld_hazard, mem_req, mem_addr, mem_wdata, mem_be, mem_pc,
           empty, count
  );

endinterface

// File: rtl/store_buffer_be_lane_merge.sv
// Byte-lane merge of a new store onto an existing entry.
module be_lane_merge
  import store_buffer_pkg::*;
(
  input  logic [31:0] old_data_i,
  input  logic [3:0]  old_be_i,
  input  logic [31:0] new_data_i,
  input  logic [3:0]  new_be_i,
  output logic [31:0] merged_data_o,
  output logic [3:0]  merged_be_o
);

  always_comb begin
    merged_data_o = old_data_i;
    for (int unsigned i = 0; i < 4; i++) begin
      if (new_be_i[i]) merged_data_o[8*i +: 8] = new_data_i[8*i +: 8];
    end
    merged_be_o = (old_be_i | new_be_i) & BE_WORD;
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write FIFO with tail merging, load hazard detection and req/ack drain.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH
)(
  input  logic         clk,
  input  logic         reset,
  store_buffer_if.slave sb
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    tail_idx;
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  sb_entry_t        ram_q [DEPTH];
  sb_entry_t        head, tail;

  logic        st_act, not_full, merge_hit, push, pop, ld_hit, occupied;
  logic [31:0] merged_data;
  logic [3:0]  merged_be;
  logic [3:0]  unused_addr_lsbs;

  assign unused_addr_lsbs = {sb.st_addr[1:0], sb.ld_addr[1:0]};

  assign tail_idx = wr_ptr_q - PW'(1);
  assign tail     = ram_q[tail_idx];
  assign head     = ram_q[rd_ptr_q];
  assign occupied = (count_q != '0);

  // The lone entry sits on the memory port, so merging needs at least two.
  assign st_act    = sb.st_valid && (sb.st_be != BE_NONE);
  assign not_full  = (count_q < CW'(DEPTH));
  assign merge_hit = st_act && (count_q >= CW'(2))
                     && (tail.word_addr == word_of(sb.st_addr));
  assign push      = st_act && !merge_hit && not_full;
  assign pop       = sb.mem_ack && occupied;

  be_lane_merge u_merge (
    .old_data_i    (tail.data),
    .old_be_i      (tail.be),
    .new_data_i    (sb.st_wdata),
    .new_be_i      (sb.st_be),
    .merged_data_o (merged_data),
    .merged_be_o   (merged_be)
  );

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    if (pop) begin
      rd_ptr_d           = rd_ptr_q + PW'(1);
      valid_d[rd_ptr_q]  = 1'b0;
    end
    if (push) begin
      wr_ptr_d           = wr_ptr_q + PW'(1);
      valid_d[wr_ptr_q]  = 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  // Entry storage carries no reset; valid_q alone qualifies its contents.
  always_ff @(posedge clk) begin
    if (push) begin
      ram_q[wr_ptr_q] <= '{word_addr: word_of(sb.st_addr), data: sb.st_wdata,
                           be: sb.st_be, pc: sb.st_pc};
    end else if (merge_hit) begin
      ram_q[tail_idx].data <= merged_data;
      ram_q[tail_idx].be   <= merged_be;
      ram_q[tail_idx].pc   <= sb.st_pc;
    end
  end

  always_comb begin
    ld_hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (ram_q[i].word_addr == word_of(sb.ld_addr))) ld_hit = 1'b1;
    end
  end

  assign sb.ld_hazard = sb.ld_valid && ld_hit;
  assign sb.st_ready  = not_full || merge_hit || (sb.st_be == BE_NONE);
  assign sb.mem_req   = occupied;
  assign sb.empty     = !occupied;
  assign sb.count     = count_q;
  assign sb.mem_addr  = occupied ? {head.word_addr, 2'b00} : '0;
  assign sb.mem_wdata = occupied ? head.data : '0;
  assign sb.mem_be    = occupied ? head.be   : '0;
  assign sb.mem_pc    = occupied ? head.pc   : '0;

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer against a queue-based reference model.
module tb_store_buffer;
  import store_buffer_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  store_buffer_if #(.DEPTH(DEPTH)) sbif ();

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sbif)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [29:0] wa;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] pc;
  } ref_t;

  ref_t mq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int unsigned l = 0; l < 4; l++) if (be[l]) m[8*l +: 8] = 8'hFF;
    return m;
  endfunction

  // Monitor: compares outputs against the model, then retires/applies this cycle's events.
  always @(negedge clk) begin
    int   n;
    bit   merge, push, hz;
    ref_t e;
    if (reset) begin
      mq.delete();
    end else begin
      n = mq.size();
      check("mem_req", {31'b0, sbif.mem_req}, {31'b0, n != 0});
      check("count", 32'(sbif.count), n);
      check("empty", {31'b0, sbif.empty}, {31'b0, n == 0});
      if (n == 0) begin
        check("idle_addr", sbif.mem_addr, 32'h0);
        check("idle_data", sbif.mem_wdata, 32'h0);
        check("idle_be", {28'b0, sbif.mem_be}, 32'h0);
        check("idle_pc", sbif.mem_pc, 32'h0);
      end else begin
        check("head_addr", sbif.mem_addr, {mq[0].wa, 2'b00});
        check("head_be", {28'b0, sbif.mem_be}, {28'b0, mq[0].be});
        check("head_data", sbif.mem_wdata & lane_mask(mq[0].be), mq[0].data & lane_mask(mq[0].be));
        check("head_pc", sbif.mem_pc, mq[0].pc);
      end
      merge = sbif.st_valid && (sbif.st_be != 4'b0) && (n >= 2)
              && (mq[n-1].wa == sbif.st_addr[31:2]);
      push  = sbif.st_valid && (sbif.st_be != 4'b0) && !merge && (n < DEPTH);
      if (sbif.st_valid)
        check("st_ready", {31'b0, sbif.st_ready},
              {31'b0, (n < DEPTH) || merge || (sbif.st_be == 4'b0)});
      hz = 1'b0;
      foreach (mq[i]) if (mq[i].wa == sbif.ld_addr[31:2]) hz = 1'b1;
      check("ld_hazard", {31'b0, sbif.ld_hazard}, {31'b0, sbif.ld_valid && hz});
      if (sbif.mem_ack && n != 0) void'(mq.pop_front());
      if (merge) begin
        e = mq[mq.size()-1];
        for (int unsigned l = 0; l < 4; l++)
          if (sbif.st_be[l]) e.data[8*l +: 8] = sbif.st_wdata[8*l +: 8];
        e.be = e.be | sbif.st_be;
        e.pc = sbif.st_pc;
        mq[mq.size()-1] = e;
      end else if (push) begin
        mq.push_back('{wa: sbif.st_addr[31:2], data: sbif.st_wdata, be: sbif.st_be, pc: sbif.st_pc});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sbif.st_valid = 1'b0;
    sbif.st_be    = 4'b0;
    sbif.ld_valid = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic [31:0] pc);
    sbif.ld_valid = 1'b0;
    sbif.st_valid = 1'b1;
    sbif.st_addr  = a;
    sbif.st_wdata = d;
    sbif.st_be    = be;
    sbif.st_pc    = pc;
  endtask

  task automatic drain();
    int unsigned guard;
    idle();
    sbif.mem_ack = 1'b1;
    guard = 0;
    while (!sbif.empty && guard < 50) begin
      step();
      guard++;
    end
    check("drain_done", {31'b0, sbif.empty}, 32'h1);
    sbif.mem_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sbif.st_valid = 1'b0; sbif.st_addr = '0; sbif.st_wdata = '0;
    sbif.st_be = '0; sbif.st_pc = '0; sbif.ld_valid = 1'b0;
    sbif.ld_addr = '0; sbif.mem_ack = 1'b0;

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("rst_mem_req", {31'b0, sbif.mem_req}, 32'h0);
    check("rst_empty", {31'b0, sbif.empty}, 32'h1);
    check("rst_st_ready", {31'b0, sbif.st_ready}, 32'h1);
    check("rst_ld_hazard", {31'b0, sbif.ld_hazard}, 32'h0);
    check("rst_mem_addr", sbif.mem_addr, 32'h0);

    // single word store drained immediately
    sbif.mem_ack = 1'b1;
    store(32'h10, 32'h11223344, BE_WORD, 32'h100);
    step(); idle();
    check("t1_req", {31'b0, sbif.mem_req}, 32'h1);
    check("t1_addr", sbif.mem_addr, 32'h10);
    check("t1_be", {28'b0, sbif.mem_be}, 32'hF);
    check("t1_data", sbif.mem_wdata, 32'h11223344);
    step();
    check("t1_empty", {31'b0, sbif.empty}, 32'h1);

    // merge into tail
    sbif.mem_ack = 1'b0;
    store(32'h20, 32'h000000AA, 4'b0001, 32'h200); step();
    store(32'h24, 32'hCAFEBABE, BE_WORD, 32'h204); step();
    store(32'h26, 32'h00BB0000, 4'b0100, 32'h208); step();
    idle();
    check("t2_count", 32'(sbif.count), 32'd2);
    check("t2_first_addr", sbif.mem_addr, 32'h20);
    sbif.mem_ack = 1'b1; step();
    check("t2_tail_addr", sbif.mem_addr, 32'h24);
    check("t2_tail_be", {28'b0, sbif.mem_be}, 32'hF);
    check("t2_tail_data", sbif.mem_wdata, 32'hCABBBABE);
    check("t2_tail_pc", sbif.mem_pc, 32'h208);
    step();
    check("t2_empty", {31'b0, sbif.empty}, 32'h1);
    sbif.mem_ack = 1'b0;

    // full buffer back-pressure, then merge into the full tail
    for (int i = 0; i < 4; i++) begin
      store(32'h40 + 32'(4*i), $urandom, BE_WORD, 32'h300 + 32'(4*i));
      step();
    end
    store(32'h50, 32'h55555555, BE_WORD, 32'h3E0);
    #1 check("t3_full_ready", {31'b0, sbif.st_ready}, 32'h0);
    step();
    check("t3_full_count", 32'(sbif.count), 32'd4);
    store(32'h4C, 32'h0000DD00, 4'b0010, 32'h3F0);
    #1 check("t3_merge_ready", {31'b0, sbif.st_ready}, 32'h1);
    step(); idle();
    check("t3_merge_count", 32'(sbif.count), 32'd4);
    drain();

    // load hazard
    store(32'h30, 32'h01020304, BE_WORD, 32'h400); step(); idle();
    sbif.ld_valid = 1'b1; sbif.ld_addr = 32'h32;
    #1 check("t4_hit", {31'b0, sbif.ld_hazard}, 32'h1);
    sbif.mem_ack = 1'b1; step(); sbif.mem_ack = 1'b0;
    check("t4_after_drain", {31'b0, sbif.ld_hazard}, 32'h0);
    store(32'h30, 32'h05060708, BE_WORD, 32'h404); step(); idle();
    sbif.ld_valid = 1'b1; sbif.ld_addr = 32'h34;
    #1 check("t4_other_word", {31'b0, sbif.ld_hazard}, 32'h0);
    step();
    drain();

    // streaming with ack held high: count steady, pointers wrap
    store(32'h100, 32'hA0A0A0A0, BE_WORD, 32'h500); step();
    store(32'h104, 32'hA1A1A1A1, BE_WORD, 32'h504); step();
    sbif.mem_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      store(32'h108 + 32'(8*i), $urandom, BE_WORD, 32'h508 + 32'(4*i));
      step();
      check("t5_count", 32'(sbif.count), 32'd2);
    end
    drain();

    // reset mid-transfer
    for (int i = 0; i < 3; i++) begin
      store(32'h200 + 32'(4*i), $urandom, BE_WORD, 32'h600 + 32'(4*i));
      step();
    end
    idle();
    check("t6_count", 32'(sbif.count), 32'd3);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_req", {31'b0, sbif.mem_req}, 32'h0);
    check("t6_rst_count", 32'(sbif.count), 32'h0);
    check("t6_rst_ready", {31'b0, sbif.st_ready}, 32'h1);
    step();
    reset = 1'b0;
    sbif.mem_ack = 1'b1;
    step();
    check("t6_ack_noeffect", 32'(sbif.count), 32'h0);
    sbif.mem_ack = 1'b0;

    // randomized traffic over a small address window
    for (int i = 0; i < 400; i++) begin
      int unsigned kind;
      idle();
      kind = $urandom_range(0, 9);
      if (kind < 6) begin
        store(32'h80 + 32'($urandom_range(0, 5) << 2) + 32'($urandom_range(0, 3)),
              $urandom, 4'($urandom_range(0, 15)), $urandom);
      end else if (kind < 9) begin
        sbif.ld_valid = 1'b1;
        sbif.ld_addr  = 32'h80 + 32'($urandom_range(0, 6) << 2) + 32'($urandom_range(0, 3));
      end
      sbif.mem_ack = ($urandom_range(0, 2) == 0);
      step();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
